// File: rtl/xbus_responder.sv
// rtl/xbus_responder.sv - 8-bit register bus responder with auto-increment word memory ports.
// Optional IRQ on write-pointer wrap is built when XBUS_RESPONDER_IRQ_EN is defined.
module xbus_responder #(
   parameter int MEM_WORDS = 1024,
   localparam int ADDR_W = $clog2(MEM_WORDS)
) (
   input  logic       clk,
   input  logic       reset_n_i,
   input  logic       bus_cs_n_i,
   input  logic       bus_rd_nwr_i,
   input  logic [3:0] bus_reg_num_i,
   input  logic       bus_bytesel_i,
   input  logic [7:0] bus_data_i,
   output logic [7:0] bus_data_o,
   output logic       busy_o
`ifdef XBUS_RESPONDER_IRQ_EN
   ,
   output logic       irq_o
`endif
);

   typedef enum logic [1:0] {IDLE, WRITE, FETCH, LOAD} state_t;

   state_t      state;
   logic        cs_q, cs_qq, rd_q, bs_q;
   logic [3:0]  reg_q;
   logic [7:0]  din_q;
   logic [7:0]  hold;
   logic [15:0] wr_addr, rd_addr, incr;
   logic [15:0] op_addr, op_incr, wdata, rd_data, mem_q;
   logic        overrun;
   logic [15:0] scratch [16];
   logic [15:0] mem [MEM_WORDS];
   logic [15:0] reg_val;
   logic [15:0] commit;
   logic        access, busy;

`ifdef XBUS_RESPONDER_IRQ_EN
   logic        irq_en, irq_pend;
   logic [16:0] idx_sum;
   // Carry out of the memory index, not of the 16-bit pointer.
   assign idx_sum = 17'(op_addr[ADDR_W-1:0]) + 17'(op_incr);
`endif

   assign access = cs_qq & ~cs_q;
   assign busy   = (state != IDLE);
   assign commit = {hold, din_q};

   always_comb begin
      reg_val = 16'h0000;
      case (reg_q)
         4'd0: reg_val = wr_addr;
         4'd1: reg_val = rd_addr;
         4'd2: reg_val = rd_data;
         4'd3: reg_val = incr;
         4'd4: reg_val = {14'b0, overrun, busy};
`ifdef XBUS_RESPONDER_IRQ_EN
         4'd5: reg_val = {14'b0, irq_pend, irq_en};
`endif
         default: reg_val = scratch[reg_q];
      endcase
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cs_q  <= 1'b1;
         cs_qq <= 1'b1;
         rd_q  <= 1'b0;
         bs_q  <= 1'b0;
         reg_q <= 4'd0;
         din_q <= 8'h00;
      end else begin
         cs_q  <= bus_cs_n_i;
         cs_qq <= cs_q;
         rd_q  <= bus_rd_nwr_i;
         bs_q  <= bus_bytesel_i;
         reg_q <= bus_reg_num_i;
         din_q <= bus_data_i;
      end
   end

   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state      <= IDLE;
         busy_o     <= 1'b0;
         bus_data_o <= 8'h00;
         hold       <= 8'h00;
         wr_addr    <= 16'h0000;
         rd_addr    <= 16'h0000;
         incr       <= 16'h0001;
         op_addr    <= 16'h0000;
         op_incr    <= 16'h0000;
         wdata      <= 16'h0000;
         rd_data    <= 16'h0000;
         overrun    <= 1'b0;
         for (int i = 0; i < 16; i++) scratch[i] <= 16'h0000;
`ifdef XBUS_RESPONDER_IRQ_EN
         irq_en     <= 1'b0;
         irq_pend   <= 1'b0;
         irq_o      <= 1'b0;
`endif
      end else begin
         case (state)
            WRITE: begin
               wr_addr <= op_addr + op_incr;
               state   <= IDLE;
               busy_o  <= 1'b0;
            end
            FETCH: state <= LOAD;
            LOAD: begin
               rd_data <= mem_q;
               state   <= IDLE;
               busy_o  <= 1'b0;
            end
            default: ;
         endcase

         // A CPU register write lands after the engine update so it wins the same edge.
         if (access) begin
            if (rd_q) begin
               bus_data_o <= bs_q ? reg_val[7:0] : reg_val[15:8];
               if (bs_q && reg_q == 4'd2) begin
                  if (busy) begin
                     overrun <= 1'b1;
                  end else begin
                     rd_addr <= rd_addr + incr;
                     op_addr <= rd_addr + incr;
                     state   <= FETCH;
                     busy_o  <= 1'b1;
                  end
               end
            end else if (!bs_q) begin
               hold <= din_q;
            end else begin
               case (reg_q)
                  4'd0: wr_addr <= commit;
                  4'd1: begin
                     if (busy) begin
                        overrun <= 1'b1;
                     end else begin
                        rd_addr <= commit;
                        op_addr <= commit;
                        state   <= FETCH;
                        busy_o  <= 1'b1;
                     end
                  end
                  4'd2: begin
                     if (busy) begin
                        overrun <= 1'b1;
                     end else begin
                        wdata   <= commit;
                        op_addr <= wr_addr;
                        op_incr <= incr;
                        state   <= WRITE;
                        busy_o  <= 1'b1;
                     end
                  end
                  4'd3: incr <= commit;
                  4'd4: if (commit[1]) overrun <= 1'b0;
`ifdef XBUS_RESPONDER_IRQ_EN
                  4'd5: begin
                     irq_en <= commit[0];
                     if (commit[1]) irq_pend <= 1'b0;
                  end
`endif
                  default: scratch[reg_q] <= commit;
               endcase
            end
         end

`ifdef XBUS_RESPONDER_IRQ_EN
         if (state == WRITE && idx_sum >= 17'(MEM_WORDS)) irq_pend <= 1'b1;
         irq_o <= irq_en & irq_pend;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (state == WRITE) mem[op_addr[ADDR_W-1:0]] <= wdata;
      if (state == FETCH) mem_q <= mem[op_addr[ADDR_W-1:0]];
   end

endmodule
